// File: rtl/hazard_pkg.sv
// hazard_pkg: state encoding, md counter width and load-use detection shared by the hazard controller
package hazard_pkg;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    HALT    = 2'd2
  } state_t;
  localparam int MD_CNT_W = 4;
  function automatic logic load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic       uses_rs,
    input logic [4:0] rs,
    input logic       uses_rt,
    input logic [4:0] rt
  );
    return ex_mem_read && ex_rd != 5'd0 &&
           ((uses_rs && ex_rd == rs) || (uses_rt && ex_rd == rt));
  endfunction
endpackage

// File: rtl/hazard_perf_counters.sv
// hazard_perf_counters: free-running stall-cycle and redirect-flush counters, wrapping at 2^CNT_W
module hazard_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;
  // count one event per cycle on each input; cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(i_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(i_flush);
    end
  end
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use/redirect/mult-div/halt sequencing for the 5-stage pipe; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MD_LATENCY = 5,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_md_op,
  input  logic             id_halt,
  input  logic             id_redirect,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  output logic             pc_write,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_t              r_state;
  logic [MD_CNT_W-1:0] r_md_cnt;
  logic                w_lu;
  logic                w_run;
  logic                w_md;
  logic                w_hlt;
  assign w_lu  = load_use(ex_mem_read, ex_rd, id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign w_run = r_state == RUN;
  assign w_md  = r_state == MD_WAIT;
  assign w_hlt = r_state == HALT;
  // controls decode straight from state and ID/EX inputs so they settle before the negedge pipe update
  always_comb begin
    pc_write    = w_run && !w_lu && !id_halt;
    ifid_stall  = !w_run || w_lu;
    ifid_flush  = w_run && !w_lu && !id_halt && id_redirect;
    idex_stall  = w_md;
    idex_flush  = w_hlt || (w_run && (w_lu || id_halt));
    exmem_flush = w_md;
    halted      = w_hlt;
  end
  // sequencing: a load-use stall defers every other ID request; mult/div holds EX for MD_LATENCY cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_md_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_lu && id_halt)
            r_state <= HALT;
          else if (!w_lu && !id_redirect && id_md_op) begin
            r_state  <= MD_WAIT;
            r_md_cnt <= MD_CNT_W'(MD_LATENCY - 1);
          end
        end
        MD_WAIT: begin
          r_md_cnt <= r_md_cnt - 1'b1;
          r_state  <= r_md_cnt == MD_CNT_W'(1) ? RUN : MD_WAIT;
        end
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .rst         (rst),
    .i_stall     (!pc_write && !w_hlt),
    .i_flush     (ifid_flush),
    .o_stall_cnt (stall_cnt),
    .o_flush_cnt (flush_cnt)
  );
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed scoreboard bench for the hazard controller (counters checked when HAZARD_PERF_CNT_EN is set)
module tb_pipeline_hazard_ctrl;
`ifdef HAZARD_PERF_CNT_EN
  localparam bit PC = 1'b1;
`else
  localparam bit PC = 1'b0;
`endif
  localparam logic [6:0] DEF = 7'b1000000;
  localparam logic [6:0] LU  = 7'b0100100;
  localparam logic [6:0] RED = 7'b1010000;
  localparam logic [6:0] MDW = 7'b0101010;
  localparam logic [6:0] HEN = 7'b0000100;
  localparam logic [6:0] HLT = 7'b0100101;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt, id_md_op, id_halt, id_redirect, ex_mem_read;
  logic        pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, halted;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  obs;
  logic [6:0]  exp_q[$];
  string       tag_q[$];
  logic [31:0] m_sc, m_fc;
  int          n_chk, n_fail;
  always #5 clk = ~clk;
  assign obs = {pc_write, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_flush, halted};
  pipeline_hazard_ctrl #(.MD_LATENCY(5), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_md_op(id_md_op), .id_halt(id_halt), .id_redirect(id_redirect),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .pc_write(pc_write), .ifid_stall(ifid_stall),
    .ifid_flush(ifid_flush), .idex_stall(idex_stall), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic idle();
    {id_rs, id_rt, ex_rd} = '0;
    {id_uses_rs, id_uses_rt, id_md_op, id_halt, id_redirect, ex_mem_read} = '0;
  endtask
  task automatic cyc(input string tag, input logic [6:0] e);
    logic [6:0] ev;
    string t;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    ev = exp_q.pop_front();
    t  = tag_q.pop_front();
    chk({t, "/ctl"}, 64'(obs), 64'(ev));
    chk({t, "/stall_cnt"}, 64'(stall_cnt), PC ? 64'(m_sc) : 64'd0);
    chk({t, "/flush_cnt"}, 64'(flush_cnt), PC ? 64'(m_fc) : 64'd0);
    @(posedge clk);
    m_sc = rst ? 32'd0 : m_sc + 32'(!ev[6] && !ev[0]);
    m_fc = rst ? 32'd0 : m_fc + 32'(ev[4]);
    #1;
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    m_sc = 0;
    m_fc = 0;
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    cyc("reset", DEF);
    rst = 1'b0;
    cyc("idle", DEF);
    ex_mem_read = 1; ex_rd = 5'd8; id_uses_rs = 1; id_rs = 5'd8;
    cyc("lu_rs", LU);
    ex_mem_read = 0;
    cyc("lu_rs_clear", DEF);
    ex_mem_read = 1; id_uses_rs = 0; id_rs = 5'd3; id_uses_rt = 1; id_rt = 5'd8;
    cyc("lu_rt", LU);
    id_uses_rt = 0;
    cyc("rt_unused", DEF);
    ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
    cyc("rd_zero", DEF);
    idle();
    id_redirect = 1;
    cyc("redirect", RED);
    id_redirect = 0;
    cyc("redirect_done", DEF);
    id_redirect = 1; ex_mem_read = 1; ex_rd = 5'd9; id_uses_rs = 1; id_rs = 5'd9;
    cyc("redir_lu", LU);
    ex_mem_read = 0;
    cyc("redir_after_lu", RED);
    idle();
    cyc("after_redir", DEF);
    rst = 1'b1;
    cyc("rst_pre_md", DEF);
    rst = 1'b0;
    id_md_op = 1;
    cyc("md_issue", DEF);
    id_md_op = 0; id_halt = 1; id_redirect = 1;
    cyc("md_w1", MDW);
    cyc("md_w2", MDW);
    cyc("md_w3", MDW);
    idle();
    cyc("md_w4", MDW);
    cyc("md_done", DEF);
    cyc("md_cnt", DEF);
    id_md_op = 1;
    cyc("md2_issue", DEF);
    id_md_op = 0;
    cyc("md2_w1", MDW);
    rst = 1'b1;
    cyc("md2_w2_rst", MDW);
    rst = 1'b0;
    cyc("md2_after_rst", DEF);
    id_halt = 1; ex_mem_read = 1; ex_rd = 5'd4; id_uses_rt = 1; id_rt = 5'd4;
    cyc("halt_lu", LU);
    ex_mem_read = 0; id_redirect = 1;
    cyc("halt_entry", HEN);
    idle();
    for (int i = 0; i < 20; i++) begin
      id_redirect = i[0];
      id_md_op = i[1];
      cyc($sformatf("halt_%0d", i), HLT);
    end
    idle();
    rst = 1'b1;
    cyc("halt_rst", HLT);
    rst = 1'b0;
    cyc("post_halt", DEF);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
